bcd_conv_seq: RTL and testbench

Sequential controller for binary-to-BCD conversion using the shift-add-3 (double-dabble) algorithm. It runs one bit per clock instead of unrolling the loop combinationally. A binary word is accepted over a valid/ready handshake, converted over DATA_W cycles, and held on the output under a valid/ready handshake. It sits between a binary counter or measurement source and the display/decoder logic that consumes the packed BCD digits.

---
 rtl/bcd_conv_seq.sv | 139 +++++++++++++
 tb/tb_bcd_conv_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per clock, valid/ready on both sides.
// Optional LEAD_ZERO_BLANK_EN adds a registered leading-zero blank mask output.
module bcd_conv_seq #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef LEAD_ZERO_BLANK_EN
  output logic [DIGITS-1:0]     blank_mask,
`endif
  output logic                  busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [DIGITS*4-1:0] dig_q, dig_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d;

  logic [DIGITS*4-1:0] dig_adj;
  logic [DIGITS*4-1:0] dig_shift;
  logic [DATA_W-1:0]   bin_shift;

  // Add-3 correction on every digit in parallel; a digit never exceeds 12 afterwards.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign dig_adj[gi*4 +: 4] = (dig_q[gi*4 +: 4] >= 4'd5) ?
                                  dig_q[gi*4 +: 4] + 4'd3 : dig_q[gi*4 +: 4];
    end
  endgenerate

  // The top digit's MSB falls off the shift; it is always 0 when 10^DIGITS > 2^DATA_W - 1.
  assign {dig_shift, bin_shift} = {dig_adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    dig_d   = dig_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_data;
          dig_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_shift;
        dig_d = dig_shift;
        if (cnt_q == '0) begin
          bcd_d   = dig_shift;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      dig_q   <= dig_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;

`ifdef LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] mask_next;
  logic              zero_run;

  // Walk down from the top digit; digit 0 is always shown.
  always_comb begin
    mask_next = '0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run & (dig_shift[k*4 +: 4] == 4'd0);
      mask_next[k] = zero_run;
    end
  end

  always_comb begin
    blank_d = blank_q;
    if (state_q == SHIFT && cnt_q == '0) begin
      blank_d = mask_next;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_mask = blank_q;
`endif

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Scoreboard bench for bcd_conv_seq: driver pushes expected BCD, negedge monitor pops on each output handshake.
module tb_bcd_conv_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [9:0]  in10;
  logic        iv10, ir10, ov10, or10, busy10;
  logic [15:0] bcd10;

`ifdef LEAD_ZERO_BLANK_EN
  logic [3:0]  blank_mask;
  logic [3:0]  mask10;
`endif

  always #5 sys_clk = ~sys_clk;

  bcd_conv_seq #(.DATA_W(8), .DIGITS(4)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LEAD_ZERO_BLANK_EN
    .blank_mask(blank_mask),
`endif
    .busy      (busy)
  );

  bcd_conv_seq #(.DATA_W(10), .DIGITS(4)) u_dut10 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_data   (in10),
    .in_valid  (iv10),
    .in_ready  (ir10),
    .bcd_out   (bcd10),
    .out_valid (ov10),
    .out_ready (or10),
`ifdef LEAD_ZERO_BLANK_EN
    .blank_mask(mask10),
`endif
    .busy      (busy10)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pushed = 0;
  int          n_seen   = 0;
  bit          rand_en  = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [15:0] b);
    logic [3:0] m;
    bit         run;
    m   = 4'b0000;
    run = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      run  = run && (b[k*4 +: 4] == 4'd0);
      m[k] = run;
    end
    return m;
  endfunction

  // Assumes the caller sits at posedge+1; returns at posedge+1 after the accept edge (or after latency checks).
  task automatic send(input logic [7:0] v, input logic [15:0] exp, input bit push, input bit chk_lat);
    int t = 0;
    while (!in_ready && t < 300) begin
      @(posedge sys_clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_data  = v;
    in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      n_pushed++;
    end
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    if (chk_lat) begin
      check("busy_after_accept", 32'(busy), 32'd1);
      check("in_ready_low_shift", 32'(in_ready), 32'd0);
      for (int i = 1; i < 8; i++) begin
        @(posedge sys_clk); #1;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
          check("latency_early", {30'd0, out_valid, in_ready}, 32'd0);
      end
      @(posedge sys_clk); #1;
      check("latency_valid", 32'(out_valid), 32'd1);
    end
  endtask

  // Monitor: one line per completed output transaction.
  logic [15:0] prev_bcd;
  bit          prev_hold = 1'b0;
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n !== 1'b1) begin
        prev_hold = 1'b0;
      end else if (out_valid === 1'b1) begin
        if (prev_hold) check("bcd_stable_stall", 32'(bcd_out), 32'(prev_bcd));
        if (out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(bcd_out), 32'hFFFF_FFFF);
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_seen++;
            check("bcd_out", 32'(bcd_out), 32'(e));
`ifdef LEAD_ZERO_BLANK_EN
            check("blank_mask", 32'(blank_mask), 32'(exp_mask(e)));
`endif
            $display("out: bcd_out=%04h expected=%04h", bcd_out, e);
          end
        end
        prev_hold = (out_ready !== 1'b1);
        prev_bcd  = bcd_out;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk); #1;
      if (rand_en) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    sys_rst_n = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in10      = '0;
    iv10      = 1'b0;
    or10      = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_bcd_out", 32'(bcd_out), 32'd0);
`ifdef LEAD_ZERO_BLANK_EN
    check("rst_blank_mask", 32'(blank_mask), 32'd0);
`endif
    sys_rst_n = 1'b1;

    // Single conversion with exact latency.
    out_ready = 1'b1;
    send(8'd162, 16'h0162, 1'b1, 1'b1);
    @(posedge sys_clk); #1;

    // Back-to-back extremes.
    send(8'd255, 16'h0255, 1'b1, 1'b1);
    send(8'd0,   16'h0000, 1'b1, 1'b1);
    @(posedge sys_clk); #1;

    // Long output stall.
    out_ready = 1'b0;
    send(8'd99, 16'h0099, 1'b1, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge sys_clk); #1;
      t++;
    end
    check("stall_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd_out !== 16'h0099)
        check("stall_hold", {15'd0, out_valid, in_ready, bcd_out}, {15'd0, 1'b1, 1'b0, 16'h0099});
    end
    check("stall_bcd", 32'(bcd_out), 32'h0099);
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("idle_keeps_bcd", 32'(bcd_out), 32'h0099);

    // Reset in the middle of a conversion discards it.
    send(8'd200, 16'h0200, 1'b0, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_bcd_out", 32'(bcd_out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    send(8'd7, 16'h0007, 1'b1, 1'b1);
    @(posedge sys_clk); #1;

    // Full sweep with random output stalls.
    rand_en = 1'b1;
    for (int i = 0; i < 256; i++) send(8'(i), to_bcd(i), 1'b1, 1'b0);
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge sys_clk); #1;
      t++;
    end
    rand_en = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("results_seen", 32'(n_seen), 32'(n_pushed));

    // Wider instance: 10-bit input, 10-cycle latency.
    t = 0;
    while (!ir10 && t < 50) begin
      @(posedge sys_clk); #1;
      t++;
    end
    in10 = 10'd1023;
    iv10 = 1'b1;
    @(posedge sys_clk); #1;
    iv10 = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge sys_clk); #1;
      if (ov10 !== 1'b0) check("w10_latency_early", 32'(ov10), 32'd0);
    end
    @(posedge sys_clk); #1;
    check("w10_out_valid", 32'(ov10), 32'd1);
    check("w10_bcd_out", 32'(bcd10), 32'h1023);
`ifdef LEAD_ZERO_BLANK_EN
    check("w10_blank_mask", 32'(mask10), 32'd0);
`endif
    $display("w10: bcd_out=%04h expected=1023", bcd10);

    repeat (2) @(posedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
